// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response handshake bundle for alu_share_arbiter
interface alu_share_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [1:0]        req0_op;
    logic [TAG_W-1:0]  req0_tag;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [1:0]        req1_op;
    logic [TAG_W-1:0]  req1_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [TAG_W-1:0]  rsp_tag;
    logic [DATA_W:0]   rsp_result;

    // Requesters and response consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_tag,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op, req1_tag,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_result,
        output rsp_ready
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_tag,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, req1_tag,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_result,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU_BLOCK between two requesters (optional CC register: ALU_ARB_CC_EN)
module alu_share_arbiter #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arbiter_if.slave bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_s0,
    output logic              alu_s1,
    input  logic [DATA_W:0]   alu_result
`ifdef ALU_ARB_CC_EN
    ,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]        state;
    logic              last_grant;   // requester granted most recently; reset to 1 so requester 0 wins first
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic              id_q;
    logic [DATA_W:0]   result_q;
    logic              rsp_valid_q;

    logic grant_vld;
    logic grant_id;
    logic accept;

    // Grant selection: a lone requester wins outright, a tie goes to the one not granted last
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant;
        end else if (bus.req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (bus.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    // Ready is only offered in IDLE, and never while reset is held
    assign accept         = rst_n && (state == ST_IDLE) && grant_vld;
    assign bus.req0_ready = accept && !grant_id;
    assign bus.req1_ready = accept && grant_id;

    // Main FSM: latch the granted operation, capture the ALU result, hold until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            id_q        <= 1'b0;
            result_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        last_grant <= grant_id;
                        id_q       <= grant_id;
                        a_q        <= grant_id ? bus.req1_a   : bus.req0_a;
                        b_q        <= grant_id ? bus.req1_b   : bus.req0_b;
                        op_q       <= grant_id ? bus.req1_op  : bus.req0_op;
                        tag_q      <= grant_id ? bus.req1_tag : bus.req0_tag;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q    <= alu_result;
                    rsp_valid_q <= 1'b1;
                    state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_s0 = op_q[0];
    assign alu_s1 = op_q[1];

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_tag    = tag_q;

`ifdef ALU_ARB_CC_EN
    logic a_msb;
    logic b_msb;
    logic r_msb;
    logic of_next;

    assign a_msb = a_q[DATA_W-1];
    assign b_msb = b_q[DATA_W-1];
    assign r_msb = alu_result[DATA_W-1];

    // Signed overflow for the current operation; logical ops never overflow
    always_comb begin
        of_next = 1'b0;
        case (op_q)
            2'b00:   of_next = (a_msb == b_msb) && (r_msb != a_msb);
            2'b01:   of_next = (a_msb != b_msb) && (r_msb != a_msb);
            default: of_next = 1'b0;
        endcase
    end

    // Condition codes track execute-stage (requester 0) results only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_zf <= 1'b0;
            cc_sf <= 1'b0;
            cc_of <= 1'b0;
        end else if ((state == ST_EXEC) && !id_q) begin
            cc_zf <= (alu_result[DATA_W-1:0] == '0);
            cc_sf <= r_msb;
            cc_of <= of_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed and randomized checks of alu_share_arbiter against a reference model
module tb_alu_share_arbiter;

    typedef struct {
        bit          id;
        logic [3:0]  tag;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  op;
    } op_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic        alu_s0;
    logic        alu_s1;
    logic [64:0] alu_result;
`ifdef ALU_ARB_CC_EN
    logic        cc_zf;
    logic        cc_sf;
    logic        cc_of;
    logic        m_zf;
    logic        m_sf;
    logic        m_of;
`endif

    int n_checks;
    int n_pass;
    int n_fail;
    bit last_grant_m;
    op_t pend_q[$];

    alu_share_arbiter_if #(.DATA_W(64), .TAG_W(4)) bus ();

    alu_share_arbiter #(.DATA_W(64), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s0     (alu_s0),
        .alu_s1     (alu_s1),
        .alu_result (alu_result)
`ifdef ALU_ARB_CC_EN
        ,
        .cc_zf      (cc_zf),
        .cc_sf      (cc_sf),
        .cc_of      (cc_of)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for ALU_BLOCK
    always_comb begin
        case ({alu_s1, alu_s0})
            2'b00:   alu_result = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   alu_result = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
            2'b10:   alu_result = {1'b0, alu_a & alu_b};
            default: alu_result = {1'b0, alu_a ^ alu_b};
        endcase
    end

    function automatic logic [64:0] ref_alu(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {(a >= b) ? 1'b1 : 1'b0, a - b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input op_t o);
        if (!o.id) begin
            bus.req0_a = o.a; bus.req0_b = o.b; bus.req0_op = o.op; bus.req0_tag = o.tag;
        end else begin
            bus.req1_a = o.a; bus.req1_b = o.b; bus.req1_op = o.op; bus.req1_tag = o.tag;
        end
    endtask

    function automatic op_t rand_op(input bit id);
        op_t o;
        o.id  = id;
        o.a   = {$urandom, $urandom};
        o.b   = ($urandom_range(0, 3) == 0) ? o.a : {$urandom, $urandom};
        o.op  = 2'($urandom_range(0, 3));
        o.tag = 4'($urandom_range(0, 15));
        return o;
    endfunction

    // Checks a presented response; the CC model follows requester-0 results
    task automatic check_rsp(input op_t o);
        logic [64:0] r;
        r = ref_alu(o.a, o.b, o.op);
        chk("rsp_valid", bus.rsp_valid, 1'b1);
        chk("rsp_result", bus.rsp_result, r);
        chk("rsp_id", bus.rsp_id, o.id);
        chk("rsp_tag", bus.rsp_tag, o.tag);
`ifdef ALU_ARB_CC_EN
        if (!o.id) begin
            m_zf = (r[63:0] == 64'd0);
            m_sf = r[63];
            if (o.op == 2'b00)      m_of = (o.a[63] == o.b[63]) && (r[63] != o.a[63]);
            else if (o.op == 2'b01) m_of = (o.a[63] != o.b[63]) && (r[63] != o.a[63]);
            else                    m_of = 1'b0;
        end
        chk("cc_zf", cc_zf, m_zf);
        chk("cc_sf", cc_sf, m_sf);
        chk("cc_of", cc_of, m_of);
`endif
    endtask

    // One isolated operation from IDLE through to the response being consumed
    task automatic single_op(input op_t o);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        drive_req(o);
        if (!o.id) bus.req0_valid = 1'b1; else bus.req1_valid = 1'b1;
        #1;
        chk("grant_r0", bus.req0_ready, !o.id);
        chk("grant_r1", bus.req1_ready, o.id);
        last_grant_m = o.id;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("exec_no_rsp", bus.rsp_valid, 1'b0);
        chk("alu_a", alu_a, o.a);
        chk("alu_b", alu_b, o.b);
        chk("alu_op", {alu_s1, alu_s0}, o.op);
        @(negedge clk);
        check_rsp(o);
        @(negedge clk);
        chk("rsp_cleared", bus.rsp_valid, 1'b0);
        chk("alu_a_hold", alu_a, o.a);
    endtask

    function automatic op_t mk(input bit id, input logic [63:0] a, input logic [63:0] b,
                               input logic [1:0] op, input logic [3:0] tag);
        op_t o;
        o.id = id; o.a = a; o.b = b; o.op = op; o.tag = tag;
        return o;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        op_t exp_o;
        bit  g;
        n_checks = 0; n_pass = 0; n_fail = 0;
        last_grant_m = 1'b1;
`ifdef ALU_ARB_CC_EN
        m_zf = 1'b0; m_sf = 1'b0; m_of = 1'b0;
`endif
        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0; bus.req0_tag = '0;
        bus.req1_valid = 1'b1; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0; bus.req1_tag = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_r0", bus.req0_ready, 1'b0);
        chk("rst_r1", bus.req1_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_result", bus.rsp_result, 65'd0);
        chk("rst_rsp_tag", bus.rsp_tag, 4'd0);
        chk("rst_rsp_id", bus.rsp_id, 1'b0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_alu_op", {alu_s1, alu_s0}, 2'd0);
`ifdef ALU_ARB_CC_EN
        chk("rst_cc", {cc_zf, cc_sf, cc_of}, 3'd0);
`endif
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b1;

        // Directed arithmetic cases
        single_op(mk(1'b0, 64'd5, 64'd7, 2'b00, 4'hA));
        single_op(mk(1'b0, 64'd5, 64'd5, 2'b01, 4'h3));
        single_op(mk(1'b0, 64'd3, 64'd5, 2'b01, 4'h4));
        single_op(mk(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 4'h5));
        single_op(mk(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FF0_0FF0_0FF0_0FF0, 2'b11, 4'h6));
        single_op(mk(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 4'h7));
        single_op(mk(1'b0, 64'hF0F0_F0F0_0000_FFFF, 64'hFF00_FF00_FFFF_0000, 2'b10, 4'h8));

        // Randomized isolated operations
        repeat (16) single_op(rand_op(1'($urandom_range(0, 1))));

        // Both requesters continuously valid: alternating 1-cycle grants every 3 cycles
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            drive_req(rand_op(1'b0));
            drive_req(rand_op(1'b1));
            #1;
            if (k % 3 == 0) begin
                g = ~last_grant_m;
                chk("rr_r0", bus.req0_ready, !g);
                chk("rr_r1", bus.req1_ready, g);
                if (!g) o = mk(1'b0, bus.req0_a, bus.req0_b, bus.req0_op, bus.req0_tag);
                else    o = mk(1'b1, bus.req1_a, bus.req1_b, bus.req1_op, bus.req1_tag);
                pend_q.push_back(o);
                last_grant_m = g;
            end else begin
                chk("rr_idle_r", {bus.req0_ready, bus.req1_ready}, 2'b00);
            end
            if (k % 3 == 1) chk("rr_exec_rsp", bus.rsp_valid, 1'b0);
            if (k % 3 == 2) begin
                if (pend_q.size() == 0) chk("rr_queue", 1'b0, 1'b1);
                else begin
                    exp_o = pend_q.pop_front();
                    check_rsp(exp_o);
                end
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Response stall: result stays stable and no new grant while rsp_ready is low
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        o = rand_op(1'b1);
        drive_req(o);
        bus.req1_valid = 1'b1;
        #1;
        chk("stall_grant", bus.req1_ready, 1'b1);
        last_grant_m = 1'b1;
        @(negedge clk);
        exp_o = rand_op(1'b0);
        drive_req(exp_o);
        bus.req0_valid = 1'b1;
        #1;
        chk("stall_exec_r0", bus.req0_ready, 1'b0);
        @(negedge clk);
        check_rsp(o);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", bus.rsp_valid, 1'b1);
            chk("stall_result", bus.rsp_result, ref_alu(o.a, o.b, o.op));
            chk("stall_tag", bus.rsp_tag, o.tag);
            chk("stall_id", bus.rsp_id, 1'b1);
            chk("stall_no_grant", {bus.req0_ready, bus.req1_ready}, 2'b00);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("stall_released", bus.rsp_valid, 1'b0);
        chk("stall_next_r0", bus.req0_ready, 1'b1);
        chk("stall_next_r1", bus.req1_ready, 1'b0);
        last_grant_m = 1'b0;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check_rsp(exp_o);
        @(negedge clk);

        // Asynchronous reset during EXEC discards the operation
        o = mk(1'b1, 64'd9, 64'd4, 2'b00, 4'h5);
        drive_req(o);
        bus.req1_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        chk("prerst_grant", bus.req1_ready, 1'b1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_exec_valid", bus.rsp_valid, 1'b0);
        chk("rst_exec_alu_a", alu_a, 64'd0);
        chk("rst_exec_tag", bus.rsp_tag, 4'd0);
`ifdef ALU_ARB_CC_EN
        m_zf = 1'b0; m_sf = 1'b0; m_of = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_grant_m = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_rsp", bus.rsp_valid, 1'b0);
        end
        o = rand_op(1'b0);
        exp_o = rand_op(1'b1);
        drive_req(o);
        drive_req(exp_o);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("post_rst_r0", bus.req0_ready, 1'b1);
        chk("post_rst_r1", bus.req1_ready, 1'b0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check_rsp(o);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
